// File: rtl/rr_encoder.sv
// Request-vector to registered binary index encoder with a valid/ready output and one-hot grant pulse.
// Define RR_ENCODER_ROUND_ROBIN_EN for round-robin selection; otherwise index 0 has fixed highest priority.
module rr_encoder #(
    parameter  int unsigned INPUTS   = 8,
    localparam int unsigned IDX_BITS = $clog2(INPUTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INPUTS-1:0]   req,
    output logic [IDX_BITS-1:0] out_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INPUTS-1:0]   gnt,
    output logic [IDX_BITS-1:0] ptr
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [IDX_BITS-1:0]   ptr_q, ptr_d;

    logic                  hs_c;
    logic [INPUTS-1:0]     gnt_c;
    logic [INPUTS-1:0]     eff_c;
    logic                  sel_hit_c;
    logic [IDX_BITS-1:0]   sel_idx_c;
    logic [IDX_BITS-1:0]   ptr_next_c;
    int unsigned           cand_c;

    // Handshake and grant pulse; the just-granted requester is masked from the search.
    assign hs_c  = (state_q == HOLD) && out_ready;
    assign gnt_c = (hs_c && !reset) ? (INPUTS'(1) << idx_q) : '0;
    assign eff_c = req & ~gnt_c;

    assign ptr_next_c = (idx_q == IDX_BITS'(INPUTS - 1)) ? '0 : idx_q + IDX_BITS'(1);

    // Pick the first set bit of eff_c, scanning from ptr (round-robin) or from 0 (fixed).
    always_comb begin
        sel_hit_c = 1'b0;
        sel_idx_c = '0;
        cand_c    = 0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
`ifdef RR_ENCODER_ROUND_ROBIN_EN
            cand_c = 32'(ptr_q) + i;
            if (cand_c >= INPUTS) begin
                cand_c = cand_c - INPUTS;
            end
`else
            cand_c = i;
`endif
            if (!sel_hit_c && eff_c[IDX_BITS'(cand_c)]) begin
                sel_hit_c = 1'b1;
                sel_idx_c = IDX_BITS'(cand_c);
            end
        end
    end

    // Next-state logic: load when empty, hold under backpressure, reload back-to-back on handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            EMPTY: begin
                if (sel_hit_c) begin
                    idx_d   = sel_idx_c;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hs_c) begin
                    ptr_d = ptr_next_c;
                    if (sel_hit_c) begin
                        idx_d = sel_idx_c;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_idx   = idx_q;
    assign out_valid = (state_q == HOLD);
    assign ptr       = ptr_q;
    assign gnt       = gnt_c;

endmodule

// File: tb/tb_rr_encoder.sv
// Self-checking bench for rr_encoder (INPUTS=8): directed scenarios plus a random phase against a reference model.
// Expected grant order follows RR_ENCODER_ROUND_ROBIN_EN when defined.
module tb_rr_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_valid;
    logic [7:0] gnt;
    logic [2:0] ptr;

    always #5 clk = ~clk;

    rr_encoder #(.INPUTS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gnt       (gnt),
        .ptr       (ptr)
    );

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic [7:0] gnt;
        logic [2:0] ptr;
    } obs_t;

    obs_t       exp_q[$];
    logic [7:0] gnt_exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    logic       m_valid = 1'b0;
    logic [2:0] m_idx   = 3'd0;
    logic [2:0] m_ptr   = 3'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference selection: rotate the doubled vector by p, take the lowest set bit.
    function automatic logic [2:0] m_sel(input logic [7:0] eff, input logic [2:0] p, output logic hit);
        logic [15:0] d;
        hit   = 1'b0;
        m_sel = 3'd0;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        d = {eff, eff} >> p;
        for (int k = 0; k < 8; k++) begin
            if (!hit && d[k]) begin
                hit   = 1'b1;
                m_sel = p + 3'(k);
            end
        end
`else
        d = 16'(eff);
        for (int k = 0; k < 8; k++) begin
            if (!hit && d[k]) begin
                hit   = 1'b1;
                m_sel = 3'(k);
            end
        end
`endif
    endfunction

    // One clock cycle: drive at negedge, push expectation, compare 1 ns later, advance the model.
    task automatic cyc(input logic r, input logic [7:0] rq, input logic rdy);
        obs_t       e;
        logic       hs;
        logic       hit;
        logic [7:0] eg;
        logic [7:0] eff;
        logic [2:0] s;
        @(negedge clk);
        reset     = r;
        req       = rq;
        out_ready = rdy;
        hs = m_valid && rdy;
        eg = (hs && !r) ? (8'h01 << m_idx) : 8'h00;
        e  = '{valid: m_valid, idx: m_idx, gnt: eg, ptr: m_ptr};
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check("out_valid", 32'(out_valid), 32'(e.valid));
        check("out_idx",   32'(out_idx),   32'(e.idx));
        check("gnt",       32'(gnt),       32'(e.gnt));
        check("ptr",       32'(ptr),       32'(e.ptr));
        if (gnt != 8'h00 && gnt_exp_q.size() > 0) begin
            check("gnt_seq", 32'(gnt), 32'(gnt_exp_q.pop_front()));
        end
        eff = rq & ~eg;
        s   = m_sel(eff, m_ptr, hit);
        if (r) begin
            m_valid = 1'b0;
            m_idx   = 3'd0;
            m_ptr   = 3'd0;
        end else if (!m_valid) begin
            if (hit) begin
                m_valid = 1'b1;
                m_idx   = s;
            end
        end else if (hs) begin
            m_ptr = (m_idx == 3'd7) ? 3'd0 : m_idx + 3'd1;
            if (hit) m_idx = s;
            else     m_valid = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b0;

        // Reset held two cycles with all requests high, then selection one cycle after release.
        cyc(1'b1, 8'hFF, 1'b1);
        cyc(1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 8'hFF, 1'b0);
        cyc(1'b0, 8'hFF, 1'b0);
        check("rst_release_idx", 32'(out_idx), 32'd0);

        // Constant req 1000_0011 with ready high: one grant per cycle.
        cyc(1'b1, 8'h00, 1'b0);
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        gnt_exp_q = '{8'h01, 8'h02, 8'h80, 8'h01, 8'h02, 8'h80};
`else
        gnt_exp_q = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02};
`endif
        for (int i = 0; i < 7; i++) cyc(1'b0, 8'h83, 1'b1);
        check("seq_drain_a", 32'(gnt_exp_q.size()), 32'd0);

        // Backpressure: index 3 held while req changes, then granted and followed by 4.
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h08, 1'b0);
        cyc(1'b0, 8'h08, 1'b0);
        cyc(1'b0, 8'h08, 1'b0);
        cyc(1'b0, 8'hF0, 1'b0);
        cyc(1'b0, 8'hF0, 1'b0);
        cyc(1'b0, 8'hF0, 1'b0);
        check("bp_hold_idx", 32'(out_idx), 32'd3);
        gnt_exp_q.push_back(8'h08);
        cyc(1'b0, 8'hF0, 1'b1);
        @(posedge clk);
        #1;
        check("bp_next_idx", 32'(out_idx), 32'd4);

        // Pointer wrap after granting index 7.
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h80, 1'b0);
        gnt_exp_q.push_back(8'h80);
        cyc(1'b0, 8'h81, 1'b1);
        @(posedge clk);
        #1;
        check("wrap_idx", 32'(out_idx), 32'd0);
        check("wrap_ptr", 32'(ptr), 32'd0);

        // Reset while holding with ready high: no grant, selection and pointer cleared.
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h06, 1'b0);
        gnt_exp_q.push_back(8'h02);
        cyc(1'b0, 8'h06, 1'b1);
        cyc(1'b1, 8'h06, 1'b1);
        check("rst_hold_gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        check("rst_hold_ptr", 32'(ptr), 32'd0);
        check("seq_drain_b", 32'(gnt_exp_q.size()), 32'd0);

        // Random traffic including all-zero requests and occasional resets.
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
